// File: rtl/rpc_digit_serial_adder.sv
// rpc_digit_serial_adder
//   Digit-serial adder/subtractor. Operands of NR_BITS are added DIGIT bits
//   per clock through a DIGIT-wide ripple slice; the carry between beats is
//   held in a register. op=1 inverts B so that c_in=1 gives a-b.
//
// Parameters
//   NR_BITS  operand/result width (multiple of DIGIT)
//   DIGIT    bits processed per clock (1..NR_BITS)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present           in_ready   block can accept operands
//   a, b       operands                   c_in       carry into bit 0
//   op         0: a+b+c_in, 1: a+~b+c_in
//   out_valid  result valid               out_ready  consumer accepts result
//   sum        result                     c_out      carry out of MSB
//   ovf        (RPC_SERIAL_OVF_EN only) signed overflow of the result
//
// Optional feature macro: RPC_SERIAL_OVF_EN adds the ovf output.
module rpc_digit_serial_adder #(
  parameter int unsigned NR_BITS = 8,
  parameter int unsigned DIGIT   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NR_BITS-1:0] a,
  input  logic [NR_BITS-1:0] b,
  input  logic               c_in,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NR_BITS-1:0] sum,
  output logic               c_out
`ifdef RPC_SERIAL_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int unsigned BEATS     = NR_BITS / DIGIT;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [NR_BITS-1:0]   r_a,         w_a_nxt;
  logic [NR_BITS-1:0]   r_b,         w_b_nxt;
  logic [NR_BITS-1:0]   r_acc,       w_acc_nxt;
  logic                 r_carry,     w_carry_nxt;
  logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
  logic [NR_BITS-1:0]   r_sum,       w_sum_nxt;
  logic                 r_c_out,     w_c_out_nxt;
  logic                 r_in_ready,  w_in_ready_nxt;
  logic                 r_out_valid, w_out_valid_nxt;

  logic [DIGIT:0]           w_digit_sum;
  logic [NR_BITS+DIGIT-1:0] w_acc_cat;
  logic [NR_BITS-1:0]       w_acc_shift;

  // One ripple slice: DIGIT LSBs of each operand plus the inter-beat carry
  assign w_digit_sum = (DIGIT+1)'(r_a[DIGIT-1:0]) + (DIGIT+1)'(r_b[DIGIT-1:0])
                     + (DIGIT+1)'(r_carry);

  // New digit enters the accumulator at the MSB end, older digits move down
  assign w_acc_cat   = {w_digit_sum[DIGIT-1:0], r_acc};
  assign w_acc_shift = w_acc_cat[NR_BITS+DIGIT-1:DIGIT];

`ifdef RPC_SERIAL_OVF_EN
  logic r_ovf, w_ovf_nxt;
  logic w_c_msb_in;

  // Carry into the top bit recovered from that bit's sum and operands
  assign w_c_msb_in = w_digit_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_c_out_nxt = r_c_out;
`ifdef RPC_SERIAL_OVF_EN
    w_ovf_nxt   = r_ovf;
`endif

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_nxt     = a;
          w_b_nxt     = b ^ {NR_BITS{op}};
          w_acc_nxt   = '0;
          w_carry_nxt = c_in;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_a_nxt     = r_a >> DIGIT;
        w_b_nxt     = r_b >> DIGIT;
        w_acc_nxt   = w_acc_shift;
        w_carry_nxt = w_digit_sum[DIGIT];
        w_cnt_nxt   = CNT_W'(r_cnt + CNT_W'(1));
        if (r_cnt == LAST_BEAT) begin
          // Result is published only when complete; sum holds otherwise
          w_sum_nxt   = w_acc_shift;
          w_c_out_nxt = w_digit_sum[DIGIT];
`ifdef RPC_SERIAL_OVF_EN
          w_ovf_nxt   = w_c_msb_in ^ w_digit_sum[DIGIT];
`endif
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Handshake flags track the next state so they come straight from flops
    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef RPC_SERIAL_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_acc       <= w_acc_nxt;
      r_carry     <= w_carry_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_c_out     <= w_c_out_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef RPC_SERIAL_OVF_EN
      r_ovf       <= w_ovf_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
`ifdef RPC_SERIAL_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
